// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, flag bit
// positions, run modes and the sequencer state encoding.
package alu_seq_pkg;

  localparam logic [7:0] OP_MOV = 8'h0D;
  localparam logic [7:0] OP_ADD = 8'h05;
  localparam logic [7:0] OP_SUB = 8'h09;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;
  localparam int unsigned FLAGS_W = 5;

  typedef enum logic [1:0] {
    MODE_FIB   = 2'd0,
    MODE_ACC   = 2'd1,
    MODE_CNTDN = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_STEP   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/alu_seq_decode.sv
// Maps sequencer state, run mode and FIB write pointer to the datapath
// control word (opcode, operand selects, immediate, write enables).
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OP_W     = 8,
  parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  state_e              state_i,
  input  mode_e               mode_i,
  input  logic [SEL_W-1:0]    w_i,
  input  logic [DATA_W-1:0]   seed_a_i,
  input  logic [DATA_W-1:0]   seed_b_i,
  output logic [OP_W-1:0]     alu_op_c,
  output logic [SEL_W-1:0]    a_sel_c,
  output logic [SEL_W-1:0]    b_sel_c,
  output logic                imm_sel_c,
  output logic [DATA_W-1:0]   imm_c,
  output logic [NUM_REGS-1:0] reg_en_c,
  output logic                flags_en_c
);

  // Non-writing states (IDLE, WAIT, DONE) leave the control word at zero.
  always_comb begin
    alu_op_c   = '0;
    a_sel_c    = '0;
    b_sel_c    = '0;
    imm_sel_c  = 1'b0;
    imm_c      = '0;
    reg_en_c   = '0;
    flags_en_c = 1'b0;
    case (state_i)
      ST_LOAD_A: begin
        if (mode_i != MODE_RSVD) begin
          alu_op_c  = OP_W'(OP_MOV);
          imm_sel_c = 1'b1;
          imm_c     = seed_a_i;
          reg_en_c  = NUM_REGS'(1);
        end
      end
      ST_LOAD_B: begin
        if (mode_i == MODE_FIB) begin
          alu_op_c  = OP_W'(OP_MOV);
          imm_sel_c = 1'b1;
          imm_c     = seed_b_i;
          reg_en_c  = NUM_REGS'(2);
        end
      end
      ST_STEP: begin
        flags_en_c = 1'b1;
        case (mode_i)
          MODE_FIB: begin
            alu_op_c = OP_W'(OP_ADD);
            a_sel_c  = w_i - SEL_W'(1);
            b_sel_c  = w_i - SEL_W'(2);
            reg_en_c = NUM_REGS'(1) << w_i;
          end
          MODE_ACC: begin
            alu_op_c  = OP_W'(OP_ADD);
            imm_sel_c = 1'b1;
            imm_c     = seed_b_i;
            reg_en_c  = NUM_REGS'(1);
          end
          MODE_CNTDN: begin
            alu_op_c  = OP_W'(OP_SUB);
            imm_sel_c = 1'b1;
            imm_c     = DATA_W'(1);
            reg_en_c  = NUM_REGS'(1);
          end
          default: flags_en_c = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-mode control sequencer for the register-file/ALU datapath with a
// start/done handshake, iteration limit and flag-driven termination.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OP_W     = 8,
  parameter int unsigned ITER_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [ITER_W-1:0]            iter_count,
  input  logic [DATA_W-1:0]            seed_a,
  input  logic [DATA_W-1:0]            seed_b,
  input  logic                         stop_on_carry,
  input  logic [FLAGS_W-1:0]           flags_in,
  output logic [OP_W-1:0]              alu_op,
  output logic [$clog2(NUM_REGS)-1:0]  a_sel,
  output logic [$clog2(NUM_REGS)-1:0]  b_sel,
  output logic                         imm_sel,
  output logic [DATA_W-1:0]            imm,
  output logic [NUM_REGS-1:0]          reg_en,
  output logic                         flags_en,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output logic [ITER_W-1:0]            steps_done
);

  localparam int unsigned SEL_W = $clog2(NUM_REGS);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [DATA_W-1:0]   seed_a_q, seed_a_d;
  logic [DATA_W-1:0]   seed_b_q, seed_b_d;
  logic                soc_q, soc_d;
  logic [SEL_W-1:0]    w_q, w_d;
  logic [ITER_W-1:0]   steps_q, steps_d;
  logic                aborted_q, aborted_d;

  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [SEL_W-1:0]    a_sel_q, a_sel_d;
  logic [SEL_W-1:0]    b_sel_q, b_sel_d;
  logic                imm_sel_q, imm_sel_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
  logic                flags_en_q, flags_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic carry_stop, zero_stop;
  logic unused_flags;

  // Only C and Z steer termination; the other flags pass by.
  assign unused_flags = ^{flags_in[FLAG_N], flags_in[FLAG_F], flags_in[FLAG_L]};

  assign carry_stop = soc_q && flags_in[FLAG_C] && (mode_q != MODE_CNTDN);
  assign zero_stop  = (mode_q == MODE_CNTDN) && flags_in[FLAG_Z];

  // Next-state, run latches, write pointer and step counter.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    iter_d    = iter_q;
    seed_a_d  = seed_a_q;
    seed_b_d  = seed_b_q;
    soc_d     = soc_q;
    w_d       = w_q;
    steps_d   = steps_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode_e'(mode);
          iter_d    = iter_count;
          seed_a_d  = seed_a;
          seed_b_d  = seed_b;
          soc_d     = stop_on_carry;
          w_d       = SEL_W'(2);
          steps_d   = '0;
          if (mode_e'(mode) == MODE_RSVD) begin
            state_d   = ST_DONE;
            aborted_d = 1'b1;
          end else begin
            state_d   = ST_LOAD_A;
            aborted_d = 1'b0;
          end
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: begin
        if (iter_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_STEP;
          steps_d = steps_q + ITER_W'(1);
        end
      end
      ST_STEP: begin
        state_d = ST_WAIT;
        w_d     = w_q + SEL_W'(1);
      end
      ST_WAIT: begin
        // Carry abort outranks zero and count termination.
        if (carry_stop) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (zero_stop || (steps_q == iter_q)) begin
          state_d   = ST_DONE;
          aborted_d = 1'b0;
        end else begin
          state_d = ST_STEP;
          steps_d = steps_q + ITER_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode from next-state values so the registered outputs line up with state_q.
  alu_seq_decode #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .OP_W     (OP_W),
    .SEL_W    (SEL_W)
  ) u_decode (
    .state_i    (state_d),
    .mode_i     (mode_d),
    .w_i        (w_d),
    .seed_a_i   (seed_a_d),
    .seed_b_i   (seed_b_d),
    .alu_op_c   (alu_op_d),
    .a_sel_c    (a_sel_d),
    .b_sel_c    (b_sel_d),
    .imm_sel_c  (imm_sel_d),
    .imm_c      (imm_d),
    .reg_en_c   (reg_en_d),
    .flags_en_c (flags_en_d)
  );

  assign busy_d = (state_d != ST_IDLE);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_FIB;
      iter_q     <= '0;
      seed_a_q   <= '0;
      seed_b_q   <= '0;
      soc_q      <= 1'b0;
      w_q        <= '0;
      steps_q    <= '0;
      aborted_q  <= 1'b0;
      alu_op_q   <= '0;
      a_sel_q    <= '0;
      b_sel_q    <= '0;
      imm_sel_q  <= 1'b0;
      imm_q      <= '0;
      reg_en_q   <= '0;
      flags_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      iter_q     <= iter_d;
      seed_a_q   <= seed_a_d;
      seed_b_q   <= seed_b_d;
      soc_q      <= soc_d;
      w_q        <= w_d;
      steps_q    <= steps_d;
      aborted_q  <= aborted_d;
      alu_op_q   <= alu_op_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      imm_sel_q  <= imm_sel_d;
      imm_q      <= imm_d;
      reg_en_q   <= reg_en_d;
      flags_en_q <= flags_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign a_sel      = a_sel_q;
  assign b_sel      = b_sel_q;
  assign imm_sel    = imm_sel_q;
  assign imm        = imm_q;
  assign reg_en     = reg_en_q;
  assign flags_en   = flags_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_done = steps_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench: directed runs push expected writes/completions, negedge
// monitors emulate the register file + ALU and compare what the DUTs issue.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start4, soc;
  logic [1:0]  mode;
  logic [7:0]  iter;
  logic [15:0] sa, sb;
  logic [4:0]  flags16 = '0, flags4 = '0;

  logic [7:0]  alu_op16, alu_op4;
  logic [3:0]  a_sel16, b_sel16;
  logic [1:0]  a_sel4, b_sel4;
  logic        imm_sel16, imm_sel4, flags_en16, flags_en4;
  logic [15:0] imm16, imm4, reg_en16;
  logic [3:0]  reg_en4;
  logic        busy16, busy4, done16, done4, aborted16, aborted4;
  logic [7:0]  steps16, steps4;

  alu_seq_ctrl #(.DATA_W(16), .NUM_REGS(16), .OP_W(8), .ITER_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .iter_count(iter),
    .seed_a(sa), .seed_b(sb), .stop_on_carry(soc), .flags_in(flags16),
    .alu_op(alu_op16), .a_sel(a_sel16), .b_sel(b_sel16), .imm_sel(imm_sel16),
    .imm(imm16), .reg_en(reg_en16), .flags_en(flags_en16), .busy(busy16),
    .done(done16), .aborted(aborted16), .steps_done(steps16)
  );

  alu_seq_ctrl #(.DATA_W(16), .NUM_REGS(4), .OP_W(8), .ITER_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode), .iter_count(iter),
    .seed_a(sa), .seed_b(sb), .stop_on_carry(soc), .flags_in(flags4),
    .alu_op(alu_op4), .a_sel(a_sel4), .b_sel(b_sel4), .imm_sel(imm_sel4),
    .imm(imm4), .reg_en(reg_en4), .flags_en(flags_en4), .busy(busy4),
    .done(done4), .aborted(aborted4), .steps_done(steps4)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] val;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        fe;
  } wr_t;

  typedef struct packed {
    int         cyc;
    logic [7:0] steps;
    logic       ab;
  } dn_t;

  wr_t exp_wr[$], exp_wr4[$];
  dn_t exp_dn[$], exp_dn4[$];
  logic [15:0] rf[16];
  logic [15:0] rf4[4];
  int cyc = 0, checks = 0, failures = 0;
  int done_cnt = 0, done_cnt4 = 0, dn_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [16:0] alu_f(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      OP_MOV:  return {1'b0, y};
      OP_ADD:  return {1'b0, x} + {1'b0, y};
      OP_SUB:  return {1'b0, x} - {1'b0, y};
      default: return 17'h0;
    endcase
  endfunction

  // Monitor for the 16-register instance.
  always @(negedge clk) begin
    logic [16:0] res;
    int idx;
    wr_t e;
    dn_t d;
    if (reg_en16 != '0) begin
      idx = 0;
      for (int i = 0; i < 16; i++) if (reg_en16[i]) idx = i;
      res = alu_f(alu_op16, rf[a_sel16], imm_sel16 ? imm16 : rf[b_sel16]);
      rf[idx] = res[15:0];
      if (flags_en16) flags16 = {res[15], res[15:0] == 16'h0, 1'b0, 1'b0, res[16]};
      check("onehot16", $countones(reg_en16), 1);
      if (exp_wr.size() == 0) flag_fail("unexpected_write16");
      else begin
        e = exp_wr.pop_front();
        check("wr_idx16", idx, e.idx);
        check("wr_val16", res[15:0], e.val);
        check("a_sel16", a_sel16, e.a);
        check("b_sel16", b_sel16, e.b);
        check("flags_en16", flags_en16, e.fe);
      end
    end
    if (done16) begin
      if (exp_dn.size() == 0) flag_fail("unexpected_done16");
      else begin
        d = exp_dn.pop_front();
        check("done_cycle16", cyc, d.cyc);
        check("steps16", steps16, d.steps);
        check("aborted16", aborted16, d.ab);
        check("done_busy16", busy16, 1);
      end
      done_cnt++;
    end
  end

  // Monitor for the 4-register instance.
  always @(negedge clk) begin
    logic [16:0] res;
    int idx;
    wr_t e;
    dn_t d;
    if (reg_en4 != '0) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (reg_en4[i]) idx = i;
      res = alu_f(alu_op4, rf4[a_sel4], imm_sel4 ? imm4 : rf4[b_sel4]);
      rf4[idx] = res[15:0];
      if (flags_en4) flags4 = {res[15], res[15:0] == 16'h0, 1'b0, 1'b0, res[16]};
      if (exp_wr4.size() == 0) flag_fail("unexpected_write4");
      else begin
        e = exp_wr4.pop_front();
        check("wr_idx4", idx, e.idx);
        check("wr_val4", res[15:0], e.val);
        check("a_sel4", a_sel4, e.a);
        check("b_sel4", b_sel4, e.b);
      end
    end
    if (done4) begin
      if (exp_dn4.size() == 0) flag_fail("unexpected_done4");
      else begin
        d = exp_dn4.pop_front();
        check("done_cycle4", cyc, d.cyc);
        check("steps4", steps4, d.steps);
        check("aborted4", aborted4, d.ab);
      end
      done_cnt4++;
    end
  end

  task automatic pw(input bit d4, input int i, input int v, input int a, input int b, input bit fe);
    wr_t e;
    e.idx = 4'(i); e.val = 16'(v); e.a = 4'(a); e.b = 4'(b); e.fe = fe;
    if (d4) exp_wr4.push_back(e);
    else exp_wr.push_back(e);
  endtask

  // Issue one run; k is the expected done cycle relative to the start edge (0 = none).
  task automatic go(input bit d4, input logic [1:0] m, input logic [7:0] it,
                    input logic [15:0] a, input logic [15:0] b, input logic s,
                    input int k, input logic [7:0] st, input logic ab);
    dn_t d;
    @(negedge clk);
    dn_base = d4 ? done_cnt4 : done_cnt;
    d.cyc = cyc + k; d.steps = st; d.ab = ab;
    if (k > 0) begin
      if (d4) exp_dn4.push_back(d);
      else exp_dn.push_back(d);
    end
    mode = m; iter = it; sa = a; sb = b; soc = s;
    if (d4) start4 = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
    mode = ~m; iter = 8'd1; sa = 16'hDEAD; sb = 16'hBEEF; soc = ~s;
  endtask

  task automatic wait_done(input bit d4);
    for (int i = 0; i < 300; i++) begin
      if ((d4 ? done_cnt4 : done_cnt) != dn_base) break;
      @(negedge clk);
    end
    if ((d4 ? done_cnt4 : done_cnt) == dn_base) flag_fail("done_timeout");
    @(negedge clk);
    check("leftover_writes", d4 ? exp_wr4.size() : exp_wr.size(), 0);
  endtask

  task automatic check_idle16(input string name);
    check(name, {alu_op16, a_sel16, b_sel16, imm_sel16, imm16, reg_en16, flags_en16,
                 busy16, done16, aborted16, steps16}, 64'h0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start4 = 1'b0; soc = 1'b0;
    mode = '0; iter = '0; sa = '0; sb = '0;
    repeat (3) @(negedge clk);
    check_idle16("reset_idle16");
    check("reset_busy4", {busy4, reg_en4, done4}, 0);
    reset = 1'b1;

    // FIB 0/1, 5 steps
    pw(0, 0, 0, 0, 0, 0); pw(0, 1, 1, 0, 0, 0);
    pw(0, 2, 1, 1, 0, 1); pw(0, 3, 2, 2, 1, 1); pw(0, 4, 3, 3, 2, 1);
    pw(0, 5, 5, 4, 3, 1); pw(0, 6, 8, 5, 4, 1);
    go(0, 2'd0, 8'd5, 16'd0, 16'd1, 1'b0, 13, 8'd5, 1'b0);
    wait_done(0);

    // FIB on four registers: destination wraps to r0
    pw(1, 0, 1, 0, 0, 0); pw(1, 1, 1, 0, 0, 0);
    pw(1, 2, 2, 1, 0, 1); pw(1, 3, 3, 2, 1, 1); pw(1, 0, 5, 3, 2, 1);
    go(1, 2'd0, 8'd3, 16'd1, 16'd1, 1'b0, 9, 8'd3, 1'b0);
    wait_done(1);

    // ACC with carry abort
    pw(0, 0, 16'hFFF0, 0, 0, 0); pw(0, 0, 16'hFFF8, 0, 0, 1); pw(0, 0, 16'h0000, 0, 0, 1);
    go(0, 2'd1, 8'd5, 16'hFFF0, 16'h0008, 1'b1, 7, 8'd2, 1'b1);
    wait_done(0);

    // ACC: carry and count limit coincide, carry wins
    pw(0, 0, 16'hFFF0, 0, 0, 0); pw(0, 0, 16'hFFF8, 0, 0, 1); pw(0, 0, 16'h0000, 0, 0, 1);
    go(0, 2'd1, 8'd2, 16'hFFF0, 16'h0008, 1'b1, 7, 8'd2, 1'b1);
    wait_done(0);

    // ACC without carry stop runs past the wrap
    pw(0, 0, 16'hFFF0, 0, 0, 0); pw(0, 0, 16'hFFF8, 0, 0, 1);
    pw(0, 0, 16'h0000, 0, 0, 1); pw(0, 0, 16'h0008, 0, 0, 1);
    go(0, 2'd1, 8'd3, 16'hFFF0, 16'h0008, 1'b0, 9, 8'd3, 1'b0);
    wait_done(0);

    // CNTDN terminates on zero, not on count
    pw(0, 0, 3, 0, 0, 0); pw(0, 0, 2, 0, 0, 1); pw(0, 0, 1, 0, 0, 1); pw(0, 0, 0, 0, 0, 1);
    go(0, 2'd2, 8'd10, 16'd3, 16'd0, 1'b1, 9, 8'd3, 1'b0);
    wait_done(0);

    // Reserved mode: immediate abort, no writes; aborted holds in IDLE
    go(0, 2'd3, 8'd4, 16'd5, 16'd6, 1'b0, 1, 8'd0, 1'b1);
    wait_done(0);
    @(negedge clk);
    check("aborted_hold", {busy16, aborted16}, 2'b01);

    // Zero iterations: only the loads
    pw(0, 0, 7, 0, 0, 0); pw(0, 1, 9, 0, 0, 0);
    go(0, 2'd0, 8'd0, 16'd7, 16'd9, 1'b0, 3, 8'd0, 1'b0);
    wait_done(0);

    // Reset asserted in the first WAIT
    pw(0, 0, 0, 0, 0, 0); pw(0, 1, 1, 0, 0, 0); pw(0, 2, 1, 1, 0, 1);
    go(0, 2'd0, 8'd5, 16'd0, 16'd1, 1'b0, 0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle16("mid_run_reset_idle");
    check("leftover_after_reset", exp_wr.size(), 0);
    reset = 1'b1;

    // Fresh run from w=2 with stray start pulses while busy
    pw(0, 0, 0, 0, 0, 0); pw(0, 1, 1, 0, 0, 0);
    pw(0, 2, 1, 1, 0, 1); pw(0, 3, 2, 2, 1, 1);
    go(0, 2'd0, 8'd2, 16'd0, 16'd1, 1'b0, 7, 8'd2, 1'b0);
    @(negedge clk); mode = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(0);
    repeat (2) @(negedge clk);
    check("idle_after_run", {busy16, done16, reg_en16}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
